fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the main decoder.
- Holds the PC and issues one request at a time to instruction memory.
- Captures the returned word into an instruction register and presents it, with its opcode field, to decode until decode consumes it.
- On consumption, selects the next PC from the decode/ALU redirect inputs: jump, taken branch, or sequential.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- imem_req  out  1  one-cycle fetch request strobe.
- imem_addr  out  32  fetch address, equals pc; valid when imem_req=1.
- imem_rvalid  in  1  read data valid, one pulse per request, ≥1 cycle after imem_req.
- imem_rdata  in  32  instruction word, sampled when imem_rvalid=1.
- instr  out  32  instruction register; 32'h0 (NOP) when instr_valid=0.
- instr_valid  out  1  instr/op/pc_out hold a fetched instruction.
- op  out  6  instr[31:26], feeds decoder op input.
- pc_out  out  32  address of instr.
- pcplus4  out  32  pc_out + 4, modulo 2^32.
- stall  in  1  decode hold; instr not consumed while 1.
- jump  in  1  decoder jump for current instr.
- pcsrc  in  1  branch taken (branch & zero) for current instr.
- branch_target  in  32  taken-branch target from datapath.
- fetch_count  out  32  number of instructions consumed since reset, wraps.

Behaviour:
- Reset (reset=0 at a clock edge), applied in any state, including mid-request:
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_count=0.
  - Instruction memory shares this reset; no stale imem_rvalid may arrive after reset.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: outputs idle; next state REQ unconditionally.
  - REQ: imem_req=1, imem_addr=pc, for exactly one cycle; next state WAIT. imem_rvalid in REQ is ignored.
  - WAIT: imem_req=0. On imem_rvalid=1: instr<=imem_rdata, instr_valid<=1, next state HOLD. Otherwise remain in WAIT; there is no timeout.
  - HOLD: instr_valid=1; instr, op, pc_out and pcplus4 are stable.
    - stall=1: remain in HOLD; no register changes.
    - stall=0: instruction consumed this cycle. fetch_count+=1, instr<=0, instr_valid<=0, next state REQ.
    - pc update on consume, in priority order:
      - jump=1: pc <= {pcplus4[31:28], instr[25:0], 2'b00}.
      - else pcsrc=1: pc <= {branch_target[31:2], 2'b00}.
      - else: pc <= pc+4.
    - jump and pcsrc both 1: jump wins.
- jump, pcsrc and branch_target are sampled only in HOLD with stall=0; ignored in all other states and cycles.
- Latency: consume edge → imem_req the next cycle → instr_valid the cycle after imem_rvalid.
  - With 1-cycle memory, back-to-back consumes give one instruction per 3 cycles.
- Arithmetic:
  - pc+4 wraps from 32'hFFFF_FFFC to 32'h0000_0000.
  - fetch_count wraps from 32'hFFFF_FFFF to 0.
  - The PC low two bits are always 0.
- pc_out = pc register. pc changes only on the consume edge, so pc_out is stable in HOLD.
- No more than one request is outstanding; imem_req never asserts in WAIT or HOLD.

Test Plan:
- Reset/start: hold reset=0 for 3 cycles, release.
  - Expect imem_req=0 during reset and on the first cycle after release.
  - Then imem_req=1 with imem_addr=32'h0 for exactly 1 cycle.
  - fetch_count=0.
- Sequential fetch: memory returns 32'h2008_0005 (ADDI) after 1 cycle, stall=0.
  - Expect op=6'b001000, pc_out=0, pcplus4=4.
  - Next request at addr 4; fetch_count=1 after consume.
- Stall: hold stall=1 for 5 cycles in HOLD.
  - instr, pc_out and fetch_count are unchanged.
  - No imem_req.
  - Release stall → request at pc+4 on the next cycle.
- Jump: at pc=32'h0040_0010, instr=32'h0810_0000.
  - jump=1 and pcsrc=1 on consume → next imem_addr=32'h0040_0000 (jump wins).
- Branch: pcsrc=1, branch_target=32'h0000_0103, jump=0 → next imem_addr=32'h0000_0100.
- Wrap and reset mid-op:
  - pc=32'hFFFF_FFFC consumed sequentially → next addr 32'h0.
  - reset=0 asserted while in WAIT → IDLE, pc=RESET_PC, instr_valid=0, and an imem_rvalid pulse in REQ after release is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time,
// holds the returned word for decode and selects the next PC when decode consumes it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  op,
  output logic [31:0] pc_out,
  output logic [31:0] pcplus4,
  input  logic        stall,
  input  logic        jump,
  input  logic        pcsrc,
  input  logic [31:0] branch_target,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] count_reg, count_next;
  logic        valid_reg, valid_next;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_reg + 32'd4;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC & 32'hFFFF_FFFC;
      instr_reg <= 32'h0;
      valid_reg <= 1'b0;
      count_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    valid_next = valid_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: state_next = REQ;
      // Any rvalid seen here belongs to no request of ours, so it is dropped.
      REQ:  state_next = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          instr_next = imem_rdata;
          valid_next = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          count_next = count_reg + 32'd1;
          instr_next = 32'h0;
          valid_next = 1'b0;
          state_next = REQ;
          // Jump outranks a taken branch when decode raises both.
          if (jump)
            pc_next = {pc_plus4[31:28], instr_reg[25:0], 2'b00};
          else if (pcsrc)
            pc_next = branch_target & 32'hFFFF_FFFC;
          else
            pc_next = pc_plus4;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign imem_req    = (state_reg == REQ);
  assign imem_addr   = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = valid_reg;
  assign pc_out      = pc_reg;
  assign pcplus4     = pc_plus4;
  assign fetch_count = count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_op
      assign op[gi] = instr_reg[26 + gi];
    end
  endgenerate

endmodule
